// File: rtl/countdown_bcd_formatter.sv
// countdown_bcd_formatter: converts a 16-bit seconds count into six BCD digits (HH:MM:SS)
// Ports: clk, reset (sync, active-high), in_seconds/in_valid/in_ready (input handshake),
//        digits (24-bit HH:MM:SS BCD, double-buffered), out_valid (one-cycle update pulse).
// Macro FORMATTER_BLANK_EN: when defined, leading zero digits are replaced by BLANK_CODE.
module countdown_bcd_formatter
`ifdef FORMATTER_BLANK_EN
#(
    parameter logic [3:0] BLANK_CODE = 4'hF
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_seconds,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] digits,
    output logic        out_valid
);
    typedef enum logic [1:0] {IDLE, DIV_S, DIV_M, SPLIT} state_t;
    state_t state, state_next;
    logic [15:0] q, q_next;
    logic [5:0]  rem, rem_next, sec, min;
    logic [4:0]  hr;
    logic [3:0]  cnt;
    logic [6:0]  trial;
    logic        ge;
    logic [23:0] raw, digits_next;
    // Tens/ones split by compare-subtract against 10..90; ones is the final remainder.
    function automatic logic [7:0] split(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int i = 1; i <= 9; i++)
            if (v >= 7'(10 * i)) begin
                t = 4'(i);
                r = v - 7'(10 * i);
            end
        return {t, 4'(r)};
    endfunction
    assign in_ready = (state == IDLE);
    // One restoring-division step: shift next dividend bit into the partial remainder.
    assign trial    = {rem, q[15]};
    assign ge       = trial >= 7'd60;
    assign rem_next = ge ? 6'(trial - 7'd60) : trial[5:0];
    assign q_next   = {q[14:0], ge};
    assign raw      = {split({2'b0, hr}), split({1'b0, min}), split({1'b0, sec})};
    always_comb begin
        digits_next = raw;
`ifdef FORMATTER_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = 5; i >= 1; i--) begin
                lead = lead && (raw[4*i +: 4] == 4'd0);
                if (lead) digits_next[4*i +: 4] = BLANK_CODE;
            end
        end
`endif
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? DIV_S : IDLE;
            DIV_S:   state_next = (cnt == 4'd15) ? DIV_M : DIV_S;
            DIV_M:   state_next = (cnt == 4'd15) ? SPLIT : DIV_M;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            rem       <= '0;
            cnt       <= '0;
            sec       <= '0;
            min       <= '0;
            hr        <= '0;
            digits    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    q   <= in_seconds;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV_S, DIV_M: begin
                    q   <= q_next;
                    cnt <= cnt + 4'd1;
                    // Partial remainder restarts at zero for the minutes division.
                    rem <= (cnt == 4'd15) ? 6'd0 : rem_next;
                    if (cnt == 4'd15) begin
                        if (state == DIV_S) sec <= rem_next;
                        else begin
                            min <= rem_next;
                            hr  <= q_next[4:0];
                        end
                    end
                end
                default: begin
                    digits    <= digits_next;
                    out_valid <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_bcd_formatter.sv
// tb_countdown_bcd_formatter: directed table-driven bench for countdown_bcd_formatter
module tb_countdown_bcd_formatter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_seconds;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] digits;
    logic        out_valid;
    int errors = 0;
    int checks = 0;

    countdown_bcd_formatter dut (
        .clk(clk), .reset(reset), .in_seconds(in_seconds), .in_valid(in_valid),
        .in_ready(in_ready), .digits(digits), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] secs;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[10];

    function automatic logic [23:0] pick(input logic [23:0] plain, input logic [23:0] blanked);
`ifdef FORMATTER_BLANK_EN
        return blanked;
`else
        return plain;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic convert(input string name, input logic [15:0] v, input logic [23:0] e);
        int   lat;
        logic busy;
        @(negedge clk);
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        in_seconds = v;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        busy = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
            else if (in_ready) busy = 1'b0;
        end
        chk({name, "_latency"}, 32'(lat), 32'd33);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_digits"}, 32'(digits), 32'(e));
        @(posedge clk);
        #1 chk({name, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"s3725",  16'd3725,  pick(24'h010205, 24'hF10205)};
        vecs[1] = '{"s65535", 16'd65535, pick(24'h181215, 24'h181215)};
        vecs[2] = '{"s0",     16'd0,     pick(24'h000000, 24'hFFFFF0)};
        vecs[3] = '{"s59",    16'd59,    pick(24'h000059, 24'hFFFF59)};
        vecs[4] = '{"s60",    16'd60,    pick(24'h000100, 24'hFFF100)};
        vecs[5] = '{"s3599",  16'd3599,  pick(24'h005959, 24'hFF5959)};
        vecs[6] = '{"s65",    16'd65,    pick(24'h000105, 24'hFFF105)};
        vecs[7] = '{"s600",   16'd600,   pick(24'h001000, 24'hFF1000)};
        vecs[8] = '{"s36000", 16'd36000, pick(24'h100000, 24'h100000)};
        vecs[9] = '{"s7322",  16'd7322,  pick(24'h020202, 24'hF20202)};
        reset = 1'b1;
        in_valid = 1'b0;
        in_seconds = '0;
        repeat (3) @(posedge clk);
        // Reset wins over an accept presented on the same edge.
        @(negedge clk);
        in_valid = 1'b1;
        in_seconds = 16'd3725;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) convert(vecs[i].name, vecs[i].secs, vecs[i].exp);

        // Held in_valid: accepts 34 cycles apart, results in order.
        begin
            logic [15:0] vals[3];
            logic [23:0] exps[3];
            int acc_t[3];
            logic [23:0] res[3];
            int ai, ri;
            logic rdy;
            vals = '{16'd59, 16'd60, 16'd3599};
            exps = '{pick(24'h000059, 24'hFFFF59), pick(24'h000100, 24'hFFF100), pick(24'h005959, 24'hFF5959)};
            ai = 0;
            ri = 0;
            acc_t = '{-1, -1, -1};
            res = '{24'h0, 24'h0, 24'h0};
            for (int t = 0; t < 120 && ri < 3; t++) begin
                @(negedge clk);
                in_valid = (ai < 3);
                if (ai < 3) in_seconds = vals[ai];
                rdy = in_ready;
                @(posedge clk);
                if (rdy && in_valid) begin
                    acc_t[ai] = t;
                    ai++;
                end
                #1;
                if (out_valid) begin
                    res[ri] = digits;
                    ri++;
                end
            end
            in_valid = 1'b0;
            chk("held_count", 32'(ri), 32'd3);
            chk("held_gap1", 32'(acc_t[1] - acc_t[0]), 32'd34);
            chk("held_gap2", 32'(acc_t[2] - acc_t[1]), 32'd34);
            for (int i = 0; i < 3; i++) chk($sformatf("held_res%0d", i), 32'(res[i]), 32'(exps[i]));
        end

        // Input presented while busy is ignored.
        begin
            int pulses, lat;
            logic [23:0] got;
            @(negedge clk);
            in_seconds = 16'd3725;
            in_valid = 1'b1;
            @(posedge clk);
            pulses = 0;
            lat = 0;
            got = '0;
            for (int k = 1; k <= 75; k++) begin
                @(negedge clk);
                in_valid = (k >= 5 && k <= 20);
                in_seconds = in_valid ? 16'd100 : 16'd0;
                @(posedge clk);
                #1;
                if (out_valid) begin
                    pulses++;
                    got = digits;
                    if (lat == 0) lat = k;
                end
            end
            in_valid = 1'b0;
            chk("busy_pulses", 32'(pulses), 32'd1);
            chk("busy_latency", 32'(lat), 32'd33);
            chk("busy_digits", 32'(got), 32'(pick(24'h010205, 24'hF10205)));
        end

        // Reset mid-conversion aborts and clears.
        convert("pre_rst", 16'd3725, pick(24'h010205, 24'hF10205));
        begin
            int pulses;
            @(negedge clk);
            in_seconds = 16'd7322;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            chk("abort_digits", 32'(digits), 32'd0);
            chk("abort_valid", 32'(out_valid), 32'd0);
            chk("abort_ready", 32'(in_ready), 32'd1);
            pulses = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1 if (out_valid) pulses++;
            end
            chk("abort_pulses", 32'(pulses), 32'd0);
            chk("abort_hold", 32'(digits), 32'd0);
        end
        convert("post_rst", 16'd7322, pick(24'h020202, 24'hF20202));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_bcd_formatter.md
# countdown_bcd_formatter

Sequential converter that turns the alarm clock's 16-bit remaining-seconds count into six BCD digits (HH:MM:SS) for the seven-segment display driver. It sits between the countdown controller (upstream, produces seconds remaining) and the display stage (downstream, consumes one 4-bit code per digit). It uses iterative restoring division, so no wide dividers are inferred. It double-buffers its result, so the display never sees a partially converted value.

## Interface

Parameters:
- BLANK_CODE, 4'hF, digit code emitted for a blanked leading zero (Configuration feature only)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_seconds  input  16  seconds remaining, unsigned, 0–65535
- in_valid  input  1  in_seconds is valid; accepted when in_valid && in_ready at a clk edge
- in_ready  output  1  block idle, can accept; combinational from state == IDLE
- digits  output  24  BCD result: [23:20] H tens, [19:16] H ones, [15:12] M tens, [11:8] M ones, [7:4] S tens, [3:0] S ones
- out_valid  output  1  one-cycle pulse: digits just updated

## Operation

- States: IDLE, DIV_S, DIV_M, SPLIT.
- IDLE:
  - in_ready = 1.
  - On accept, latch in_seconds into the dividend register, clear the step counter, go to DIV_S.
  - in_valid while not IDLE is ignored; nothing is queued.
- DIV_S: 16-step restoring division of the latched value by 60, one quotient bit per cycle, MSB first.
  - Remainder is 6 bits (0–59) and becomes seconds.
  - Quotient is total minutes (0–1092).
  - After step 16, go to DIV_M.
- DIV_M: 16-step restoring division of total minutes by 60.
  - Quotient zero-extended to 16 bits.
  - Remainder is minutes (0–59); quotient is hours (0–18).
  - After step 16, go to SPLIT.
- SPLIT: each of hours, minutes and seconds (all < 100) splits into tens/ones by compare-subtract against 10/20/…/90. This is combinational within the state.
  - Register the result into digits.
  - Pulse out_valid.
  - Go to IDLE.
- digits holds its value between updates; only the SPLIT edge writes it.
- Working registers are separate from digits, so a conversion in progress never disturbs the displayed value.
- Arithmetic: all unsigned; no overflow is possible for 16-bit input (max 18:12:15).

## Timing

- Accept at edge N → DIV_S on edges N+1..N+16 → DIV_M on edges N+17..N+32 → SPLIT edge N+33.
- At edge N+33: digits updated, out_valid rises, in_ready rises (state IDLE).
- out_valid is high for exactly one cycle (between edges N+33 and N+34).
- Fixed latency: 33 cycles from accept edge to result edge.
- Minimum accept-to-accept spacing is 34 cycles: a new input is accepted at the earliest at edge N+34, when in_valid is held high.
- Reset values: digits = 24'h000000, out_valid = 0, state = IDLE (so in_ready = 1 in the cycle after reset).
- Reset mid-conversion:
  - Aborts the conversion; no out_valid is produced.
  - digits is cleared to 0.
  - Reset has priority over an accept on the same edge.

## Configuration

- Macro FORMATTER_BLANK_EN.
- Defined: leading zero digits are replaced by BLANK_CODE at the SPLIT edge.
  - Scanning from H tens downward, each digit is blanked while it and all higher digits are zero.
  - S ones is never blanked.
  - Example: 65 s → 24'hFFF105; 0 s → 24'hFFFFF0.
- Undefined: no blanking logic is present, and all six digits are always BCD. Example: 65 s → 24'h000105.
- Latency, handshake and reset behaviour are identical in both builds.

## Test plan

- in_seconds = 3725, in_valid pulsed one cycle at edge N → out_valid only at edge N+33, digits = 24'h010205; in_ready low for edges N+1..N+32.
- in_seconds = 65535 → digits = 24'h181215; in_seconds = 0 → 24'h000000 (FFFFF0 with FORMATTER_BLANK_EN).
- in_valid held high with values 59, 60, 3599 → accepts exactly 34 cycles apart; results 24'h000059, 24'h000100, 24'h005959, in order.
- Accept 3725, then present 100 with in_valid during cycles 5–20 → 100 is ignored; only 24'h010205 is produced.
- Complete 3725, then accept 7322 and assert reset at cycle 10 of the conversion → no out_valid, digits = 0 next cycle, in_ready = 1; a subsequent 7322 → 24'h020202.
- FORMATTER_BLANK_EN defined: 65 → 24'hFFF105; 600 → 24'hFF1000; 36000 → 24'h100000.
